// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// Handshake: start (with sub/a/b) is taken on a rising edge while busy=0; done pulses for one cycle when sum/cout/ovf update.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [1:0]       state;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, state
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, state
    );
endinterface

// File: rtl/serial_addsub.sv
// LSB-first serial adder/subtractor: one full-add cell plus a carry flop, one bit per clock.
// Subtraction is a + ~b + 1, with the +1 entering through the carry flop.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum_q;
    logic             c;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             s;
    logic             cn;

    assign accept = (state != RUN) && bus.start;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign s      = sa[0] ^ sb[0] ^ c;
    assign cn     = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            p      <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= bus.b ^ {WIDTH{bus.sub}};
            p   <= '0;
            c   <= bus.sub;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            p   <= {s, p[WIDTH-1:1]};
            c   <= cn;
            cnt <= cnt + CW'(1);
            // On the MSB cycle c is the carry into the sign bit, so cn^c is signed overflow.
            if (last) begin
                sum_q  <= {s, p[WIDTH-1:1]};
                cout_q <= cn;
                ovf_q  <= cn ^ c;
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.state = state;
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, LSB-first adder/subtractor built around a one-bit add cell and a carry flip-flop. It computes A+B or A−B over WIDTH clock cycles. It is the sequential stage that feeds operand bits into the half/full-adder cells of the adders-substractors library. Parallel operands are captured on a start handshake and a registered parallel result is returned with carry/borrow and signed-overflow flags.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = A+B, 1 = A−B; captured with start.
- a  input  WIDTH  operand A, unsigned or two's complement; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  result; holds the last completed value.
- cout  output  1  carry out for add; for sub, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow of the last completed operation.

## Operation
- Reset (async, rst_n=0): state IDLE; busy, done, sum, cout, ovf, carry flop, bit counter and shift registers all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1: capture a into shift register SA and b^{WIDTH{sub}} into SB. Carry flop ← sub. Counter ← 0. Go to RUN.
- RUN, every cycle:
  - s = SA[0]^SB[0]^c and cn = majority(SA[0],SB[0],c).
  - Shift s into the MSB of the partial register P; P shifts right.
  - SA and SB shift right; c ← cn; counter increments.
  - When counter = WIDTH−1, the cycle processes the MSB. Load sum ← final P, cout ← cn, ovf ← cn XOR carry-into-MSB. Go to DONE.
- DONE: lasts exactly one cycle, then IDLE unless start=1, which begins a new operation directly.
- start while in RUN is ignored. Operand inputs are don't-care except on the capturing edge.
- sum, cout and ovf change only on the DONE-entry edge. They hold through later RUN periods until the next completion.
- Arithmetic is modulo 2^WIDTH. The subtraction identity is a + ~b + 1.
- Counter width is clog2(WIDTH). The last bit is detected by comparison, not by natural wrap.

## Timing
- Edge E0 samples start=1 with busy=0: busy=1 after E0.
- Edges E1..E(WIDTH−1): one bit processed per edge. The MSB is processed on edge E(WIDTH):
  - done=1 and busy=0 after E(WIDTH), with results valid at the same time.
  - Latency from start accepted to done is WIDTH cycles.
- done is high for exactly one cycle. busy and done are never high together.
- Back-to-back: start=1 during the done cycle makes busy=1 on the next edge. Throughput is one operation per WIDTH+1 cycles.
- Reset mid-operation aborts immediately:
  - All outputs return to 0 and no done pulse is produced.
  - The first start after rst_n deasserts behaves as from power-up.
- Outputs are registered; there is no combinational path from any input to any output.

## Test plan
- WIDTH=8, add 0x0F+0x01 → sum=0x10, cout=0, ovf=0; done exactly 8 cycles after the start edge, single-cycle pulse.
- Add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Add 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
- Sub 0x05−0x07 → sum=0xFE, cout=0 (borrow), ovf=0. Sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Hold start=1 through RUN with changing a/b: only the first capture is computed and busy stays high for 8 cycles. Start held during the done cycle launches the next operation with no IDLE gap.
- Assert rst_n=0 at bit 4 of an add: all outputs 0 asynchronously and no done. After release, 0x12+0x34 → 0x46.
- WIDTH=4: run all 256 (a,b) pairs for both add and sub and compare sum, cout and ovf against a behavioral model. Check sum is stable while busy=1.
